// File: rtl/pwm_gen.sv
// PWM generator: free-running 2^PWM_DEPTH slot period, duty cycle taken through a
// one-deep pending slot and applied only at a period boundary (or on enable).
module pwm_gen #(
    parameter int PWM_DEPTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EN,
    input  logic [PWM_DEPTH-1:0] DC,
    input  logic                 DC_VALID,
    output logic                 DC_READY,
    output logic [PWM_DEPTH-1:0] ACTIVE_DC,
    output logic                 PWM_OUT,
    output logic                 PERIOD_START
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [PWM_DEPTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [PWM_DEPTH-1:0] cnt_q, cnt_d;
    logic [PWM_DEPTH-1:0] pend_q, pend_d;
    logic                 pend_v_q, pend_v_d;
    logic [PWM_DEPTH-1:0] active_q, active_d;
    logic                 pwm_q, pwm_d;
    logic                 ps_q, ps_d;
    logic                 accept;
    logic                 xfer;

    // Ready depends only on the pending flag, never on DC_VALID.
    assign DC_READY     = ~pend_v_q;
    assign accept       = DC_VALID & ~pend_v_q;
    assign ACTIVE_DC    = active_q;
    assign PWM_OUT      = pwm_q;
    assign PERIOD_START = ps_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            active_q <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        active_d = active_q;
        pwm_d    = pwm_q;
        ps_d     = ps_q;
        xfer     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                pwm_d = 1'b0;
                ps_d  = 1'b0;
                if (EN) begin
                    state_d = RUN;
                    xfer    = pend_v_q;
                end
            end
            RUN: begin
                if (!EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pwm_d   = 1'b0;
                    ps_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    pwm_d = (cnt_q < active_q);
                    ps_d  = (cnt_q == '0);
                    xfer  = pend_v_q && (cnt_q == CNT_MAX);
                end
            end
            default: state_d = IDLE;
        endcase

        // Transfer keys off the pre-edge flag; accept needs the flag clear,
        // so a value accepted on a wrap edge waits for the next wrap.
        if (xfer) begin
            active_d = pend_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_d   = DC;
            pend_v_d = 1'b1;
        end
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL provide parameter: PWM_DEPTH, default 12, duty-cycle and counter width (period = 2^PWM_DEPTH clocks).
REQ-002 SHALL provide port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: EN  input  1  run enable.
REQ-005 SHALL provide port: DC  input  PWM_DEPTH  requested duty cycle (consumes mixer DC_POST).
REQ-006 SHALL provide port: DC_VALID  input  1  DC offered this cycle.
REQ-007 SHALL provide port: DC_READY  output  1  pending slot free; DC accepted when DC_VALID and DC_READY at an edge.
REQ-008 SHALL provide port: ACTIVE_DC  output  PWM_DEPTH  duty cycle in use for the current period.
REQ-009 SHALL provide port: PWM_OUT  output  1  registered PWM output.
REQ-010 SHALL provide port: PERIOD_START  output  1  registered one-cycle pulse marking period slot 0.

Function
REQ-011 SHALL contain: period counter CNT (PWM_DEPTH bits), pending register PEND plus flag PEND_V, active register ACTIVE_DC, FSM with states IDLE and RUN.
REQ-012 SHALL drive DC_READY = not PEND_V, combinationally from the flag only (no DC_VALID dependency).
REQ-013 SHALL, on accept, load PEND <= DC and set PEND_V <= 1, in either state.
REQ-014 SHALL, IDLE: hold CNT at 0, PWM_OUT 0, PERIOD_START 0; go to RUN on the edge where EN=1.
REQ-015 SHALL, on the IDLE->RUN edge with PEND_V=1, transfer ACTIVE_DC <= PEND and clear PEND_V.
REQ-016 SHALL, RUN: increment CNT by 1 per clock, wrapping 2^PWM_DEPTH-1 -> 0.
REQ-017 SHALL, RUN with CNT = 2^PWM_DEPTH-1 and PEND_V=1, transfer ACTIVE_DC <= PEND and clear PEND_V on that edge; ACTIVE_DC SHALL never change at any other time except reset.
REQ-018 SHALL, when accept and transfer fall on the same edge, apply the transfer using the pre-edge PEND_V; a value accepted while PEND_V=0 SHALL wait for the next wrap (no bypass).
REQ-019 SHALL, RUN: register PWM_OUT <= (CNT < ACTIVE_DC); PWM_OUT therefore lags CNT by one clock.
REQ-020 SHALL, RUN: register PERIOD_START <= (CNT == 0), aligned with the PWM_OUT bit of slot 0.
REQ-021 SHALL give high cycles per period = ACTIVE_DC: 0 gives constant low; 2^PWM_DEPTH-1 gives one low cycle per period.
REQ-022 SHALL, RUN with EN=0 at an edge: go to IDLE, set CNT <= 0, PWM_OUT <= 0, PERIOD_START <= 0; ACTIVE_DC, PEND and PEND_V retained.
REQ-023 SHALL, on re-enable, start from slot 0 (CNT=0) with the full period.

Reset
REQ-024 SHALL, while rst_n=0, immediately and without clock force: CNT=0, PEND=0, PEND_V=0, ACTIVE_DC=0, PWM_OUT=0, PERIOD_START=0, state IDLE, DC_READY=1.
REQ-025 SHALL, on rst_n assertion mid-period, cut PWM_OUT low asynchronously and discard any pending value.
REQ-026 SHALL resume operation on the first rising clk edge after rst_n deasserts, following REQ-014.

Verification
REQ-027 SHALL cover: PWM_DEPTH=12, EN=0, accept DC=13, then EN=1 -> ACTIVE_DC=13 after the EN edge; each period has exactly 13 high then 4083 low cycles; PERIOD_START pulses every 4096 clocks.
REQ-028 SHALL cover: DC=0 then DC=4095 across two periods -> period 1 all low; period 2 has 4095 high and 1 low.
REQ-029 SHALL cover: accept DC=100 mid-period, then hold DC_VALID with DC=200 -> DC_READY=0 until the wrap; ACTIVE_DC=100 at the wrap; 200 accepted one clock later and active one period after that; no mid-period change of ACTIVE_DC.
REQ-030 SHALL cover: EN dropped at CNT=50 with ACTIVE_DC=1000 -> PWM_OUT=0 on the next clock; on re-enable, the first PERIOD_START occurs and 1000 high cycles follow from slot 0.
REQ-031 SHALL cover: rst_n pulsed low between clocks at CNT=7 with PWM_OUT=1 -> PWM_OUT=0, ACTIVE_DC=0 and DC_READY=1 before the next edge.
REQ-032 SHALL cover: accept on the same edge as the wrap with PEND_V=0 -> ACTIVE_DC unchanged that period; new value active after the following wrap.
